// File: rtl/mem_pkg.sv
// Shared memory-subsystem types: stack address helper and op decode.
package mem_pkg;

  localparam logic [19:0] DEFAULT_STACK_BASE = 20'h00000;

  typedef enum logic [2:0] {
    OP_IDLE,
    OP_PUSH,
    OP_POP,
    OP_REPL,
    OP_LOAD
  } op_e;

  function automatic logic [63:0] stack_offset(
    input logic [63:0] base,
    input logic [63:0] n,
    input logic        grow_down
  );
    return grow_down ? base - n : base + n;
  endfunction

endpackage

// File: rtl/stack_ctrl_if.sv
// Request/status bundle between a stack user and stack_ctrl.
interface stack_ctrl_if #(
  parameter int ADDR_WIDTH  = 20,
  parameter int STACK_DEPTH = 256,
  parameter int CNT_W       = $clog2(STACK_DEPTH + 1)
);
  logic                  push;
  logic                  pop;
  logic                  sp_load;
  logic [CNT_W-1:0]      sp_load_val;
  logic                  err_clr;
  logic [ADDR_WIDTH-1:0] addr_out;
  logic                  wr_en;
  logic [CNT_W-1:0]      count;
  logic                  empty;
  logic                  full;
  logic                  overflow;
  logic                  underflow;
  logic [CNT_W-1:0]      high_water;

  modport master (
    output push, pop, sp_load, sp_load_val, err_clr,
    input  addr_out, wr_en, count, empty, full,
    input  overflow, underflow, high_water
  );

  modport slave (
    input  push, pop, sp_load, sp_load_val, err_clr,
    output addr_out, wr_en, count, empty, full,
    output overflow, underflow, high_water
  );
endinterface

// File: rtl/stack_ctrl.sv
// Stack-pointer controller: occupancy, RAM address, bounds errors
// and high-water mark for one hardware stack.
module stack_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 20,
  parameter logic [ADDR_WIDTH-1:0] STACK_BASE =
    ADDR_WIDTH'(DEFAULT_STACK_BASE),
  parameter int STACK_DEPTH = 256,
  parameter int GROW_DOWN = 0,
  parameter int CNT_W = $clog2(STACK_DEPTH + 1)
) (
  input logic clk,
  input logic reset,
  stack_ctrl_if.slave bus
);

  localparam longint BASE_L = longint'(STACK_BASE);
  localparam longint TOP_L = (longint'(1) << ADDR_WIDTH) - 1;
  localparam longint LAST_L = longint'(STACK_DEPTH) - 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(STACK_DEPTH);

  if (STACK_DEPTH < 1) begin : g_bad_depth
    $error("stack_ctrl: STACK_DEPTH must be >= 1");
  end
  if (GROW_DOWN == 0 && BASE_L + LAST_L > TOP_L) begin : g_bad_up
    $error("stack_ctrl: stack region wraps past top of memory");
  end
  if (GROW_DOWN != 0 && BASE_L < LAST_L) begin : g_bad_dn
    $error("stack_ctrl: stack region wraps below address 0");
  end

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] hw_q;
  logic             ovf_q;
  logic             unf_q;

  op_e              op;
  logic [CNT_W-1:0] cnt_nxt;
  logic             ovf_set;
  logic             unf_set;
  logic             we;
  logic             is_empty;
  logic             is_full;
  logic [CNT_W-1:0] idx;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == DEPTH_C);

  always_comb begin
    op = OP_IDLE;
    unique case (1'b1)
      bus.sp_load:                            op = OP_LOAD;
      !bus.sp_load && bus.push && bus.pop:    op = OP_REPL;
      !bus.sp_load && bus.push && !bus.pop:   op = OP_PUSH;
      !bus.sp_load && !bus.push && bus.pop:   op = OP_POP;
      default:                                op = OP_IDLE;
    endcase
  end

  always_comb begin
    cnt_nxt = count_q;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    we      = 1'b0;
    unique case (op)
      OP_LOAD: begin
        if (bus.sp_load_val > DEPTH_C) begin
          cnt_nxt = DEPTH_C;
          ovf_set = 1'b1;
        end else begin
          cnt_nxt = bus.sp_load_val;
        end
      end
      OP_PUSH: begin
        if (is_full) begin
          ovf_set = 1'b1;
        end else begin
          cnt_nxt = count_q + CNT_W'(1);
          we      = 1'b1;
        end
      end
      OP_POP: begin
        if (is_empty) unf_set = 1'b1;
        else cnt_nxt = count_q - CNT_W'(1);
      end
      OP_REPL: begin
        we = 1'b1;
        // Empty replace still lands the pushed word at slot 0.
        if (is_empty) begin
          unf_set = 1'b1;
          cnt_nxt = CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    idx = '0;
    if (!reset)
      idx = '0;
    else if (bus.push && !bus.pop)
      idx = count_q;
    else if (!is_empty)
      idx = count_q - CNT_W'(1);
  end

  assign bus.addr_out = ADDR_WIDTH'(stack_offset(
    64'(STACK_BASE), 64'(idx), GROW_DOWN != 0));

  assign bus.wr_en      = we && reset;
  assign bus.count      = count_q;
  assign bus.empty      = is_empty;
  assign bus.full       = is_full;
  assign bus.overflow   = ovf_q;
  assign bus.underflow  = unf_q;
  assign bus.high_water = hw_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      hw_q    <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= cnt_nxt;
      if (bus.err_clr) begin
        hw_q  <= cnt_nxt;
        ovf_q <= ovf_set;
        unf_q <= unf_set;
      end else begin
        hw_q  <= (cnt_nxt > hw_q) ? cnt_nxt : hw_q;
        ovf_q <= ovf_q | ovf_set;
        unf_q <= unf_q | unf_set;
      end
    end
  end

endmodule
